// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
package seq_gen_pkg;

  // Default maximum pattern length, length-field width and repeat-field width.
  localparam int unsigned DefW  = 8;
  localparam int unsigned DefLW = 4;
  localparam int unsigned DefRW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits the low len bits of a captured pattern MSB-first,
// repeated reps+1 times back to back, then pulses done. All outputs are registered.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned LW = DefLW,
  parameter int unsigned RW = DefRW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] reps,
  input  logic          abort,
  output logic          o,
  output logic          o_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // One bit wider than len so that len values above W compare correctly.
  localparam logic [LW:0] LenMax = (LW + 1)'(W);

  state_e        state_q;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;   // position of the bit currently on o
  logic [RW-1:0] reps_q;
  logic [RW-1:0] pass_q;  // passes already completed in full
  logic          len_ok;

  // Shift-based select keeps the index width independent of W.
  function automatic logic bit_at(input logic [W-1:0] p, input logic [LW-1:0] i);
    logic [W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // A start request is only accepted for 1 <= len <= W.
  always_comb begin
    len_ok = (len != '0) && ({1'b0, len} <= LenMax);
  end

  // Control FSM with inline bit/pass counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          // abort suppresses a simultaneous start entirely
          if (start && !abort) begin
            if (len_ok) begin
              pat_q   <= pattern;
              len_q   <= len;
              reps_q  <= reps;
              idx_q   <= len - 1'b1;
              pass_q  <= '0;
              o       <= bit_at(pattern, len - 1'b1);
              o_valid <= 1'b1;
              busy    <= 1'b1;
              state_q <= StShift;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StShift: begin
          if (abort) begin
            o       <= 1'b0;
            o_valid <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (idx_q != '0) begin
            idx_q <= idx_q - 1'b1;
            o     <= bit_at(pat_q, idx_q - 1'b1);
          end else if (pass_q != reps_q) begin
            // next pass starts immediately with no idle gap
            pass_q <= pass_q + 1'b1;
            idx_q  <= len_q - 1'b1;
            o      <= bit_at(pat_q, len_q - 1'b1);
          end else begin
            o       <= 1'b0;
            o_valid <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          o       <= 1'b0;
          o_valid <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; each step checks {o, o_valid, busy, done, err}.
module tb_seq_pattern_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [LW-1:0] len = '0;
  logic [RW-1:0] reps = '0;
  logic          abort = 1'b0;
  logic          o;
  logic          o_valid;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] hist;
  int det;
  int vcnt;

  seq_pattern_gen #(
    .W  (W),
    .LW (LW),
    .RW (RW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .abort   (abort),
    .o       (o),
    .o_valid (o_valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Advance one edge, then compare {o, o_valid, busy, done, err}.
  task automatic step(input string tag, input logic [4:0] exp);
    logic [4:0] got;
    @(posedge clk);
    #1;
    got = {o, o_valid, busy, done, err};
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got o/ov/busy/done/err=%b expected %b", tag, got, exp);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial begin
    // Reset state
    step("reset_a", 5'b00000);
    step("reset_b", 5'b00000);
    #1 rst = 1'b1;

    // 1101, len 4, single pass
    pattern = 8'h0D; len = 4'd4; reps = 4'd0; start = 1'b1;
    step("p1_b0", 5'b11100);
    start = 1'b0;
    step("p1_b1", 5'b11100);
    step("p1_b2", 5'b01100);
    step("p1_b3", 5'b11100);
    step("p1_done", 5'b00110);
    step("p1_idle", 5'b00000);

    // 1101, len 4, two passes; count 1101 matches in the serial stream
    hist = 4'b0000; det = 0;
    pattern = 8'hFD; reps = 4'd1; start = 1'b1;  // upper bits must be ignored
    step("p2_b0", 5'b11100);
    start = 1'b0;
    if (o_valid) begin hist = {hist[2:0], o}; if (hist == 4'b1101) det++; end
    for (int i = 1; i < 8; i++) begin
      step($sformatf("p2_b%0d", i), {((i % 4) == 2) ? 1'b0 : 1'b1, 4'b1100});
      if (o_valid) begin hist = {hist[2:0], o}; if (hist == 4'b1101) det++; end
    end
    step("p2_done", 5'b00110);
    check_int("p2_detect", det, 2);
    step("p2_idle", 5'b00000);

    // Rejected lengths
    len = 4'd0; start = 1'b1;
    step("len0_err", 5'b00001);
    start = 1'b0;
    step("len0_after", 5'b00000);
    len = 4'd9; start = 1'b1;
    step("len9_err", 5'b00001);
    start = 1'b0;
    step("len9_after", 5'b00000);

    // Abort together with start in IDLE: no capture, no err
    len = 4'd4; pattern = 8'h0F; start = 1'b1; abort = 1'b1;
    step("abort_start_idle", 5'b00000);
    start = 1'b0; abort = 1'b0;
    step("abort_start_after", 5'b00000);

    // Full-width pass 1010_0110, restart attempt mid-stream, then abort
    pattern = 8'b1010_0110; len = 4'd8; reps = 4'd0; start = 1'b1;
    step("ab_b7", 5'b11100);
    start = 1'b0;
    step("ab_b6", 5'b01100);
    pattern = 8'hFF; len = 4'd2; start = 1'b1;
    step("ab_b5", 5'b11100);
    step("ab_b4", 5'b01100);
    start = 1'b0; abort = 1'b1;
    step("ab_drop", 5'b00000);
    abort = 1'b0;
    step("ab_nodone", 5'b00000);

    // Reset during bit 3 with start held high throughout
    pattern = 8'h0D; len = 4'd4; reps = 4'd0; start = 1'b1;
    step("rs_b1", 5'b11100);
    step("rs_b2", 5'b11100);
    step("rs_b3", 5'b01100);
    rst = 1'b0;
    step("rs_clear", 5'b00000);
    rst = 1'b1;
    step("rs_restart", 5'b11100);
    start = 1'b0;
    step("rs_b2b", 5'b11100);
    step("rs_b3b", 5'b01100);
    step("rs_b4b", 5'b11100);
    step("rs_done", 5'b00110);
    step("rs_idle", 5'b00000);

    // Maximum reps: 16 single-bit passes
    pattern = 8'h01; len = 4'd1; reps = 4'd15; start = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      step($sformatf("max_b%0d", i), 5'b11100);
      start = 1'b0;
      if (o_valid) vcnt++;
    end
    check_int("max_valid_cycles", vcnt, 16);
    step("max_done", 5'b00110);
    step("max_idle", 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
